// File: rtl/coffee_change_if.sv
// Coin-out handshake bundle between the vending FSM / hopper and the change dispenser.
// master: request side plus hopper acknowledge; slave: the change dispenser.
interface coffee_change_if #(
    parameter int AMT_W = 6
);
    logic             start;
    logic [AMT_W-1:0] bal_in;
    logic             coin_ack;
    logic             busy;
    logic             coin_vld;
    logic [1:0]       coin_sel;
    logic             done;
    logic             err;
    logic [AMT_W-1:0] residual;
    logic [2:0]       coin_count;

    modport master (
        output start, bal_in, coin_ack,
        input  busy, coin_vld, coin_sel, done, err, residual, coin_count
    );

    modport slave (
        input  start, bal_in, coin_ack,
        output busy, coin_vld, coin_sel, done, err, residual, coin_count
    );
endinterface

// File: rtl/coffee_change_dispenser.sv
// Change-return engine: ejects an overpayment balance as coins, largest first,
// through a valid/ack hopper handshake, then reports coin count and residual.
// Optional macro CHANGE_TIMEOUT_EN: abandon a coin the hopper never acknowledges
// after TIMEOUT cycles and finish the transaction with err set.
module coffee_change_dispenser #(
    parameter int AMT_W    = 6,
    parameter int COIN_HI  = 20,
    parameter int COIN_MID = 10,
    parameter int COIN_LO  = 5,
    parameter int TIMEOUT  = 15
) (
    input logic             clk,
    input logic             rst,
    coffee_change_if.slave  bus
);
    localparam logic [1:0] st_idle   = 2'd0;
    localparam logic [1:0] st_select = 2'd1;
    localparam logic [1:0] st_eject  = 2'd2;
    localparam logic [1:0] st_done   = 2'd3;

    localparam logic [AMT_W-1:0] val_hi  = AMT_W'(COIN_HI);
    localparam logic [AMT_W-1:0] val_mid = AMT_W'(COIN_MID);
    localparam logic [AMT_W-1:0] val_lo  = AMT_W'(COIN_LO);

    logic [1:0]       state;
    logic [AMT_W-1:0] rem;
    logic             busy;
    logic             coin_vld;
    logic [1:0]       coin_sel;
    logic             done;
    logic             err;
    logic [AMT_W-1:0] residual;
    logic [2:0]       coin_count;

    logic [1:0]       sel_next;
    logic [AMT_W-1:0] coin_val;

`ifdef CHANGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] tmo_cnt;
`endif

    // Greedy denomination choice for the current remaining amount.
    always_comb begin
        sel_next = 2'b00;
        if (rem >= val_hi) begin
            sel_next = 2'b11;
        end else if (rem >= val_mid) begin
            sel_next = 2'b10;
        end else if (rem >= val_lo) begin
            sel_next = 2'b01;
        end
    end

    // Value of the coin currently presented to the hopper.
    always_comb begin
        coin_val = '0;
        case (coin_sel)
            2'b11:   coin_val = val_hi;
            2'b10:   coin_val = val_mid;
            2'b01:   coin_val = val_lo;
            default: coin_val = '0;
        endcase
    end

    // Transaction FSM and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= st_idle;
            rem        <= '0;
            busy       <= 1'b0;
            coin_vld   <= 1'b0;
            coin_sel   <= 2'b00;
            done       <= 1'b0;
            err        <= 1'b0;
            residual   <= '0;
            coin_count <= 3'd0;
`ifdef CHANGE_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                st_idle: begin
                    if (bus.start) begin
                        rem        <= bus.bal_in;
                        coin_count <= 3'd0;
                        busy       <= 1'b1;
                        state      <= st_select;
                    end
                end
                st_select: begin
                    if (sel_next != 2'b00) begin
                        coin_sel <= sel_next;
                        coin_vld <= 1'b1;
                        state    <= st_eject;
`ifdef CHANGE_TIMEOUT_EN
                        tmo_cnt  <= '0;
`endif
                    end else begin
                        state <= st_done;
                    end
                end
                st_eject: begin
                    if (bus.coin_ack) begin
                        // Selection guarantees rem >= coin_val, so no underflow.
                        rem        <= rem - coin_val;
                        coin_count <= (coin_count == 3'd7) ? 3'd7 : coin_count + 3'd1;
                        coin_vld   <= 1'b0;
                        coin_sel   <= 2'b00;
                        state      <= st_select;
`ifdef CHANGE_TIMEOUT_EN
                    end else if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
                        // Uncollected coin stays in rem, so the residual (and err) reflect it.
                        coin_vld <= 1'b0;
                        coin_sel <= 2'b00;
                        state    <= st_done;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
`endif
                    end
                end
                st_done: begin
                    done     <= 1'b1;
                    residual <= rem;
                    err      <= (rem != '0);
                    busy     <= 1'b0;
                    state    <= st_idle;
                end
                default: state <= st_idle;
            endcase
        end
    end

    assign bus.busy       = busy;
    assign bus.coin_vld   = coin_vld;
    assign bus.coin_sel   = coin_sel;
    assign bus.done       = done;
    assign bus.err        = err;
    assign bus.residual   = residual;
    assign bus.coin_count = coin_count;

endmodule

// File: tb/tb_coffee_change_dispenser.sv
// Directed bench for coffee_change_dispenser: greedy sequence, zero and odd balances,
// delayed hopper ack, mid-transaction reset, back-to-back starts, optional timeout.
module tb_coffee_change_dispenser;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    coffee_change_if #(.AMT_W(6)) bus ();

    coffee_change_dispenser #(
        .AMT_W   (6),
        .COIN_HI (20),
        .COIN_MID(10),
        .COIN_LO (5),
        .TIMEOUT (15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start for one cycle; returns at the first negedge after the accepting edge.
    task automatic start_txn(input logic [5:0] bal);
        @(negedge clk);
        bus.bal_in = bal;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.start = 1'b0;
        bus.bal_in = '0;
        bus.coin_ack = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.coin_vld, bus.coin_sel, bus.done, bus.err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got busy/vld/sel/done/err=%b want 000000",
                     {bus.busy, bus.coin_vld, bus.coin_sel, bus.done, bus.err});
        end
        checks++;
        if (bus.residual !== 6'd0 || bus.coin_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_data: got residual=%0d count=%0d want 0 0",
                     bus.residual, bus.coin_count);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    // bal=35 with ack tied high: 20,10,5 then done 8 cycles after accept.
    task automatic test_greedy();
        logic [1:0] sels [3];
        int ncoin;
        int n;
        logic prev;
        ncoin = 0;
        prev = 1'b0;
        bus.coin_ack = 1'b1;
        start_txn(6'd35);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL greedy_busy: got %b want 1", bus.busy);
        end
        n = 0;
        while (n < 40) begin
            if (bus.coin_vld && !prev && ncoin < 3) begin
                sels[ncoin] = bus.coin_sel;
                ncoin++;
            end
            prev = bus.coin_vld;
            if (bus.done) break;
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL greedy_latency: got %0d want 8", n);
        end
        checks++;
        if (ncoin !== 3 || sels[0] !== 2'b11 || sels[1] !== 2'b10 || sels[2] !== 2'b01) begin
            errors++;
            $display("FAIL greedy_seq: got n=%0d %b %b %b want 3 11 10 01",
                     ncoin, sels[0], sels[1], sels[2]);
        end
        checks++;
        if (bus.err !== 1'b0 || bus.residual !== 6'd0 || bus.coin_count !== 3'd3) begin
            errors++;
            $display("FAIL greedy_result: got err=%b res=%0d cnt=%0d want 0 0 3",
                     bus.err, bus.residual, bus.coin_count);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL greedy_busy_end: got %b want 0", bus.busy);
        end
    endtask

    // bal=0: no coin, done two cycles after accept.
    task automatic test_zero();
        int n;
        logic saw_vld;
        saw_vld = 1'b0;
        bus.coin_ack = 1'b1;
        start_txn(6'd0);
        n = 0;
        while (n < 40) begin
            if (bus.coin_vld) saw_vld = 1'b1;
            if (bus.done) break;
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 2 || saw_vld !== 1'b0) begin
            errors++;
            $display("FAIL zero_latency: got n=%0d vld_seen=%b want 2 0", n, saw_vld);
        end
        checks++;
        if (bus.err !== 1'b0 || bus.coin_count !== 3'd0) begin
            errors++;
            $display("FAIL zero_result: got err=%b cnt=%0d want 0 0", bus.err, bus.coin_count);
        end
    endtask

    // bal=7: one 5-coin, residual 2 flagged as err.
    task automatic test_residual();
        int n;
        bus.coin_ack = 1'b1;
        start_txn(6'd7);
        @(negedge clk);
        checks++;
        if (bus.coin_vld !== 1'b1 || bus.coin_sel !== 2'b01) begin
            errors++;
            $display("FAIL resid_coin: got vld=%b sel=%b want 1 01", bus.coin_vld, bus.coin_sel);
        end
        n = 1;
        while (n < 40 && !bus.done) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL resid_latency: got %0d want 4", n);
        end
        checks++;
        if (bus.err !== 1'b1 || bus.residual !== 6'd2 || bus.coin_count !== 3'd1) begin
            errors++;
            $display("FAIL resid_result: got err=%b res=%0d cnt=%0d want 1 2 1",
                     bus.err, bus.residual, bus.coin_count);
        end
    endtask

    // bal=20, ack held off 4 cycles; a stray start mid-transaction must be ignored.
    task automatic test_slow_ack();
        int n;
        int bad;
        bad = 0;
        bus.coin_ack = 1'b0;
        start_txn(6'd20);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (bus.coin_vld !== 1'b1 || bus.coin_sel !== 2'b11) bad++;
            if (i == 2) begin
                bus.bal_in = 6'd35;
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            if (i == 4) bus.coin_ack = 1'b1;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL slow_hold: got %0d unstable cycles want 0", bad);
        end
        @(negedge clk);
        bus.coin_ack = 1'b0;
        checks++;
        if (bus.coin_vld !== 1'b0) begin
            errors++;
            $display("FAIL slow_drop: got vld=%b want 0", bus.coin_vld);
        end
        n = 5;
        while (n < 40 && !bus.done) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 7 || bus.err !== 1'b0 || bus.coin_count !== 3'd1 || bus.residual !== 6'd0) begin
            errors++;
            $display("FAIL slow_result: got n=%0d err=%b cnt=%0d res=%0d want 7 0 1 0",
                     n, bus.err, bus.coin_count, bus.residual);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL slow_ignore_start: got busy=%b want 0", bus.busy);
        end
    endtask

    // bal=40, reset during the second EJECT, then a clean bal=5 transaction.
    task automatic test_mid_reset();
        int n;
        logic saw_done;
        saw_done = 1'b0;
        bus.coin_ack = 1'b1;
        start_txn(6'd40);
        repeat (3) @(negedge clk);
        checks++;
        if (bus.coin_vld !== 1'b1 || bus.coin_count !== 3'd1) begin
            errors++;
            $display("FAIL rst_pre: got vld=%b cnt=%0d want 1 1", bus.coin_vld, bus.coin_count);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.coin_vld !== 1'b0 || bus.busy !== 1'b0 || bus.coin_count !== 3'd0 ||
            bus.coin_sel !== 2'b00) begin
            errors++;
            $display("FAIL rst_async: got vld=%b busy=%b cnt=%0d sel=%b want 0 0 0 00",
                     bus.coin_vld, bus.busy, bus.coin_count, bus.coin_sel);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_done: got done seen=%b want 0", saw_done);
        end
        start_txn(6'd5);
        n = 0;
        while (n < 40 && !bus.done) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 4 || bus.err !== 1'b0 || bus.coin_count !== 3'd1) begin
            errors++;
            $display("FAIL rst_recover: got n=%0d err=%b cnt=%0d want 4 0 1",
                     n, bus.err, bus.coin_count);
        end
    endtask

    // bal=10 then start raised in the done cycle with bal=15 (coins 10,5).
    task automatic test_back_to_back();
        int n;
        bus.coin_ack = 1'b1;
        start_txn(6'd10);
        n = 0;
        while (n < 40 && !bus.done) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 4 || bus.coin_count !== 3'd1) begin
            errors++;
            $display("FAIL b2b_first: got n=%0d cnt=%0d want 4 1", n, bus.coin_count);
        end
        bus.bal_in = 6'd15;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: got busy=%b want 1", bus.busy);
        end
        n = 0;
        while (n < 40 && !bus.done) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 6 || bus.coin_count !== 3'd2 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: got n=%0d cnt=%0d err=%b want 6 2 0",
                     n, bus.coin_count, bus.err);
        end
    endtask

`ifdef CHANGE_TIMEOUT_EN
    // bal=30, hopper never acks: coin_vld held 15 cycles then abandoned.
    task automatic test_timeout();
        int n;
        int vld_cycles;
        vld_cycles = 0;
        bus.coin_ack = 1'b0;
        start_txn(6'd30);
        n = 0;
        while (n < 60 && !bus.done) begin
            if (bus.coin_vld) vld_cycles++;
            @(negedge clk);
            n++;
        end
        checks++;
        if (vld_cycles !== 15 || n !== 17) begin
            errors++;
            $display("FAIL tmo_timing: got vld=%0d n=%0d want 15 17", vld_cycles, n);
        end
        checks++;
        if (bus.err !== 1'b1 || bus.residual !== 6'd30 || bus.coin_count !== 3'd0) begin
            errors++;
            $display("FAIL tmo_result: got err=%b res=%0d cnt=%0d want 1 30 0",
                     bus.err, bus.residual, bus.coin_count);
        end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_greedy();
        test_zero();
        test_residual();
        test_slow_ack();
        test_mid_reset();
        test_back_to_back();
`ifdef CHANGE_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/coffee_change_dispenser.md
# coffee_change_dispenser

Change-return engine for the coffee vending machine. It takes the overpayment balance computed by the vending FSM and ejects it as individual coins through a coin-hopper handshake, largest denomination first. It is the output (coin-out) end of the coin datapath that the vending FSM's coin-in side feeds. It reports completion, the number of coins ejected, and any amount that cannot be returned in the available denominations.

## Interface
Parameters:
- AMT_W, 6, width of balance and remaining-amount datapath
- COIN_HI, 20, large coin value (rupees)
- COIN_MID, 10, medium coin value
- COIN_LO, 5, small coin value
- TIMEOUT, 15, hopper acknowledge timeout in cycles (used only with CHANGE_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle request; sampled only in IDLE
- bal_in  in  AMT_W  balance to return; captured when start is accepted
- coin_ack  in  1  hopper has taken the presented coin
- busy  out  1  high from the cycle after start is accepted through DONE
- coin_vld  out  1  coin eject request to hopper
- coin_sel  out  2  denomination: 00 none, 01 COIN_LO, 10 COIN_MID, 11 COIN_HI
- done  out  1  one-cycle pulse at end of a transaction
- err  out  1  valid with done; residual non-zero or timeout
- residual  out  AMT_W  unreturned amount, valid with done
- coin_count  out  3  coins ejected this transaction, saturates at 7

## Operation
- States: IDLE, SELECT, EJECT, DONE.
- IDLE: when start=1, rem<=bal_in, coin_count<=0, busy<=1, next SELECT. Otherwise remain in IDLE.
- SELECT: apply greedy selection on rem.
  - rem>=COIN_HI: sel=11.
  - Else rem>=COIN_MID: sel=10.
  - Else rem>=COIN_LO: sel=01.
  - On a selection: coin_sel<=sel, coin_vld<=1, next EJECT.
  - Otherwise: next DONE.
- EJECT: hold coin_vld and coin_sel stable until a rising edge samples coin_ack=1.
  - On that edge: rem<=rem-value(sel), coin_count<=coin_count+1 (saturating), coin_vld<=0, coin_sel<=00, next SELECT.
- DONE: done<=1 for one cycle, residual<=rem, err<=(rem!=0), busy<=0, next IDLE.
- coin_ack is ignored outside EJECT.
- start is ignored while busy=1.
- Subtraction never underflows, because the selection guarantees rem>=value.
- Reset values:
  - state IDLE, rem 0.
  - busy, coin_vld, done, err: 0.
  - coin_sel 00, residual 0, coin_count 0.
- Asynchronous reset mid-transaction: all outputs return to reset values immediately. Coin tracking is abandoned; no done pulse is generated.

## Timing
- Start accepted at edge T: busy=1 after T, SELECT during cycle T..T+1, coin_vld=1 after edge T+1.
- With coin_ack tied high, each coin costs 2 cycles: EJECT then SELECT.
- For N coins: done asserts after edge T+2N+2 (SELECT with no coin, then DONE).
  - bal_in=0 gives done 2 cycles after start.
- done, err, residual and coin_count are stable in the done cycle. coin_count holds until the next accepted start.
- A new start is accepted in the cycle after done, back-to-back.

## Configuration
- CHANGE_TIMEOUT_EN defined:
  - A counter runs while in EJECT.
  - If coin_ack is not seen within TIMEOUT cycles of coin_vld rising, drop coin_vld and go to DONE with err=1 and residual=rem. The uncollected coin is not subtracted.
  - The counter clears on every entry to EJECT.
- CHANGE_TIMEOUT_EN undefined:
  - No counter is built; EJECT waits indefinitely.
  - err reflects only a non-zero residual.

## Test plan
- bal_in=35, coin_ack tied 1 -> coin_sel sequence 11,10,01 on successive coin_vld; done 8 cycles after start; err=0, residual=0, coin_count=3.
- bal_in=0 -> no coin_vld; done 2 cycles after start; err=0, coin_count=0.
- bal_in=7 -> single coin 01; done with err=1, residual=2, coin_count=1.
- bal_in=20, coin_ack delayed 4 cycles -> coin_vld=1 and coin_sel=11 held stable for all 4 cycles; one coin; err=0. A start pulse mid-transaction is ignored.
- bal_in=40, rst driven low during second EJECT -> coin_vld, busy, coin_count go to 0 immediately; no done. After release, start with bal_in=5 completes normally.
- With CHANGE_TIMEOUT_EN, bal_in=30, coin_ack held 0 -> coin_vld drops after 15 cycles; done with err=1, residual=30, coin_count=0.
